// File: rtl/vs_lock_ctrl.sv
// VS source scanner and lock controller.
// Steps through the eligible VS sources. For each one it holds the
// downstream filter in reset, then gives it a bounded acquisition window.
// It stays on a source while the filter reports stable lock.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | scanning disabled or no eligible source; filter held in reset
// ARM    | filter held in reset for C_ARM_CLKNUM cycles on SEL_O
// ACQ    | filter running, waiting for stable within the dwell window
// LOCKED | filter reports stable lock on SEL_O
module vs_lock_ctrl #(
  parameter int C_SRC_NUM              = 4,
  parameter int C_THRESHHOLD_CLKPRD_BW = 16,
  parameter int C_DWELL_BW             = 24,
  parameter int C_ARM_CLKNUM           = 16
) (
  input  logic                              CLK_I,
  input  logic                              RST_I,
  input  logic                              EN_I,
  input  logic [C_SRC_NUM-1:0]              SRC_MASK_I,
  input  logic [C_SRC_NUM-1:0]              VS_I,
  input  logic [C_DWELL_BW-1:0]             DWELL_CLKNUM_I,
  input  logic [7:0]                        FILTER_TIMES_I,
  input  logic [C_THRESHHOLD_CLKPRD_BW-1:0] FILTER_THRESHHOLD_CLKPRD_I,
  output logic                              FLT_RSTN_O,
  output logic                              FLT_EN_O,
  output logic [7:0]                        FLT_TIMES_O,
  output logic [C_THRESHHOLD_CLKPRD_BW-1:0] FLT_THRESHHOLD_O,
  output logic                              FLT_VS_O,
  input  logic                              FLT_STABLE_I,
  input  logic                              FLT_TIMEOUT_I,
  output logic [2:0]                        SEL_O,
  output logic                              LOCK_O,
  output logic                              LOCK_LOST_O,
  output logic                              NO_SRC_O
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ARM    = 2'd1;
  localparam logic [1:0] S_ACQ    = 2'd2;
  localparam logic [1:0] S_LOCKED = 2'd3;

  localparam int ARM_W = $clog2(C_ARM_CLKNUM + 1);
  // Down-counter reload: terminal count 0 ends the last ARM cycle.
  localparam logic [ARM_W-1:0] ARM_LOAD = ARM_W'(C_ARM_CLKNUM - 1);
  localparam logic [C_DWELL_BW:0] DWELL_ONE = (C_DWELL_BW + 1)'(1);

  logic [1:0]            st, st_nxt;
  logic [2:0]            sel_nxt;
  logic [ARM_W-1:0]      arm_cnt;
  logic [C_DWELL_BW-1:0] dwell;
  logic [C_DWELL_BW:0]   dwell_inc, dwell_lim;
  logic                  dwell_hit;
  logic                  arm_load, acq_clr, lost_nxt, flt_on_nxt;

  function automatic logic bit_at(input logic [C_SRC_NUM-1:0] vec, input logic [2:0] idx);
    logic r;
    r = 1'b0;
    for (int i = 0; i < C_SRC_NUM; i++)
      if (3'(i) == idx) r = vec[i];
    return r;
  endfunction

  function automatic logic [2:0] lowest_src(input logic [C_SRC_NUM-1:0] m);
    logic [2:0] r;
    logic       f;
    r = 3'd0;
    f = 1'b0;
    for (int i = 0; i < C_SRC_NUM; i++)
      if (m[i] && !f) begin
        r = 3'(i);
        f = 1'b1;
      end
    return r;
  endfunction

  // Next eligible index above cur, wrapping to the lowest eligible one.
  function automatic logic [2:0] next_src(input logic [C_SRC_NUM-1:0] m, input logic [2:0] cur);
    logic [2:0] r;
    logic       f;
    r = lowest_src(m);
    f = 1'b0;
    for (int i = 0; i < C_SRC_NUM; i++)
      if (m[i] && !f && (3'(i) > cur)) begin
        r = 3'(i);
        f = 1'b1;
      end
    return r;
  endfunction

  // A zero dwell setting still gives the filter one ACQ cycle.
  assign dwell_inc = {1'b0, dwell} + DWELL_ONE;
  assign dwell_lim = (DWELL_CLKNUM_I == '0) ? DWELL_ONE : {1'b0, DWELL_CLKNUM_I};
  assign dwell_hit = (dwell_inc >= dwell_lim);

  // Next-state and source selection, in priority order.
  always_comb begin
    st_nxt   = st;
    sel_nxt  = SEL_O;
    arm_load = 1'b0;
    acq_clr  = 1'b0;
    lost_nxt = 1'b0;
    if (!EN_I) begin
      st_nxt = S_IDLE;
    end else if (SRC_MASK_I == '0) begin
      st_nxt = S_IDLE;
    end else if ((st != S_IDLE) && !bit_at(SRC_MASK_I, SEL_O)) begin
      sel_nxt  = next_src(SRC_MASK_I, SEL_O);
      st_nxt   = S_ARM;
      arm_load = 1'b1;
    end else begin
      case (st)
        S_IDLE: begin
          sel_nxt  = lowest_src(SRC_MASK_I);
          st_nxt   = S_ARM;
          arm_load = 1'b1;
        end
        S_ARM: begin
          if (arm_cnt == '0) begin
            st_nxt  = S_ACQ;
            acq_clr = 1'b1;
          end
        end
        S_ACQ: begin
          if (FLT_STABLE_I) begin
            st_nxt = S_LOCKED;
          end else if (dwell_hit || FLT_TIMEOUT_I) begin
            sel_nxt  = next_src(SRC_MASK_I, SEL_O);
            st_nxt   = S_ARM;
            arm_load = 1'b1;
          end
        end
        default: begin
          if (!FLT_STABLE_I || FLT_TIMEOUT_I) begin
            st_nxt   = S_ARM;
            arm_load = 1'b1;
            lost_nxt = 1'b1;
          end
        end
      endcase
    end
  end

  assign flt_on_nxt = (st_nxt == S_ACQ) || (st_nxt == S_LOCKED);

  // State, timers and registered outputs; outputs track the next state so
  // they line up with the state register.
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      st               <= S_IDLE;
      SEL_O            <= 3'd0;
      arm_cnt          <= '0;
      dwell            <= '0;
      FLT_RSTN_O       <= 1'b0;
      FLT_EN_O         <= 1'b0;
      FLT_VS_O         <= 1'b0;
      FLT_TIMES_O      <= 8'd0;
      FLT_THRESHHOLD_O <= '0;
      LOCK_O           <= 1'b0;
      LOCK_LOST_O      <= 1'b0;
      NO_SRC_O         <= 1'b0;
    end else begin
      st    <= st_nxt;
      SEL_O <= sel_nxt;
      if (arm_load)
        arm_cnt <= ARM_LOAD;
      else if ((st == S_ARM) && (arm_cnt != '0))
        arm_cnt <= arm_cnt - 1'b1;
      if (acq_clr)
        dwell <= '0;
      else if ((st == S_ACQ) && (dwell != '1))
        dwell <= dwell_inc[C_DWELL_BW-1:0];
      if ((st == S_ARM) && (arm_cnt == ARM_LOAD)) begin
        FLT_TIMES_O      <= FILTER_TIMES_I;
        FLT_THRESHHOLD_O <= FILTER_THRESHHOLD_CLKPRD_I;
      end
      FLT_RSTN_O  <= flt_on_nxt;
      FLT_EN_O    <= flt_on_nxt;
      FLT_VS_O    <= flt_on_nxt ? bit_at(VS_I, SEL_O) : 1'b0;
      LOCK_O      <= (st_nxt == S_LOCKED);
      LOCK_LOST_O <= lost_nxt;
      NO_SRC_O    <= EN_I && (SRC_MASK_I == '0);
    end
  end

endmodule

// File: tb/tb_vs_lock_ctrl.sv
// Bench for vs_lock_ctrl: directed scenarios plus a random phase.
// A scenario-level model predicts every cycle's outputs into a queue, and
// a monitor compares them against the DUT on the falling edge.
module tb_vs_lock_ctrl;

  logic        CLK_I = 1'b0;
  logic        RST_I = 1'b1;
  logic        EN_I = 1'b0;
  logic [3:0]  SRC_MASK_I = 4'd0;
  logic [3:0]  VS_I = 4'd0;
  logic [23:0] DWELL_CLKNUM_I = 24'd0;
  logic [7:0]  FILTER_TIMES_I = 8'd0;
  logic [15:0] FILTER_THRESHHOLD_CLKPRD_I = 16'd0;
  logic        FLT_RSTN_O, FLT_EN_O, FLT_VS_O;
  logic [7:0]  FLT_TIMES_O;
  logic [15:0] FLT_THRESHHOLD_O;
  logic        FLT_STABLE_I = 1'b0;
  logic        FLT_TIMEOUT_I = 1'b0;
  logic [2:0]  SEL_O;
  logic        LOCK_O, LOCK_LOST_O, NO_SRC_O;

  vs_lock_ctrl dut (
    .CLK_I(CLK_I), .RST_I(RST_I), .EN_I(EN_I), .SRC_MASK_I(SRC_MASK_I),
    .VS_I(VS_I), .DWELL_CLKNUM_I(DWELL_CLKNUM_I), .FILTER_TIMES_I(FILTER_TIMES_I),
    .FILTER_THRESHHOLD_CLKPRD_I(FILTER_THRESHHOLD_CLKPRD_I),
    .FLT_RSTN_O(FLT_RSTN_O), .FLT_EN_O(FLT_EN_O), .FLT_TIMES_O(FLT_TIMES_O),
    .FLT_THRESHHOLD_O(FLT_THRESHHOLD_O), .FLT_VS_O(FLT_VS_O),
    .FLT_STABLE_I(FLT_STABLE_I), .FLT_TIMEOUT_I(FLT_TIMEOUT_I),
    .SEL_O(SEL_O), .LOCK_O(LOCK_O), .LOCK_LOST_O(LOCK_LOST_O), .NO_SRC_O(NO_SRC_O)
  );

  always #5 CLK_I = ~CLK_I;

  typedef struct packed {
    logic        rstn;
    logic        en;
    logic [7:0]  times;
    logic [15:0] thr;
    logic        vs;
    logic [2:0]  sel;
    logic        lock;
    logic        lost;
    logic        no_src;
  } out_t;

  out_t dut_o;
  assign dut_o = {FLT_RSTN_O, FLT_EN_O, FLT_TIMES_O, FLT_THRESHHOLD_O, FLT_VS_O,
                  SEL_O, LOCK_O, LOCK_LOST_O, NO_SRC_O};

  out_t exp_q[$];
  out_t mon_e;
  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;

  // Reference model: phase name, position inside the phase, chosen source.
  typedef enum {M_IDLE, M_ARM, M_ACQ, M_LOCK} mphase_t;
  mphase_t     m_ph = M_IDLE;
  int          m_sel = 0;
  int          m_arm_done = 0;
  int          m_acq_done = 0;
  logic [7:0]  m_times = 8'd0;
  logic [15:0] m_thr = 16'd0;
  logic        m_vs = 1'b0, m_lost = 1'b0, m_nosrc = 1'b0;

  function automatic int pick_after(int cur, logic [3:0] m);
    int elig[$];
    int r;
    bit found;
    for (int i = 0; i < 4; i++) if (m[i]) elig.push_back(i);
    r = elig[0];
    found = 0;
    for (int k = 0; k < elig.size(); k++)
      if (!found && elig[k] > cur) begin
        r = elig[k];
        found = 1;
      end
    return r;
  endfunction

  task automatic model_step();
    logic [3:0] v;
    logic       vs_old;
    int         dwell_max;
    v = VS_I;
    vs_old = v[m_sel[1:0]];
    if (RST_I) begin
      m_ph = M_IDLE; m_sel = 0; m_times = 8'd0; m_thr = 16'd0;
      m_vs = 1'b0; m_lost = 1'b0; m_nosrc = 1'b0;
      return;
    end
    m_lost = 1'b0;
    m_nosrc = EN_I && (SRC_MASK_I == 4'd0);
    if (m_ph == M_ARM && m_arm_done == 0) begin
      m_times = FILTER_TIMES_I;
      m_thr = FILTER_THRESHHOLD_CLKPRD_I;
    end
    dwell_max = (DWELL_CLKNUM_I == 24'd0) ? 1 : int'(DWELL_CLKNUM_I);
    if (!EN_I || SRC_MASK_I == 4'd0) begin
      m_ph = M_IDLE;
    end else if (m_ph != M_IDLE && !SRC_MASK_I[m_sel[1:0]]) begin
      m_sel = pick_after(m_sel, SRC_MASK_I);
      m_ph = M_ARM; m_arm_done = 0;
    end else begin
      case (m_ph)
        M_IDLE: begin
          m_sel = pick_after(-1, SRC_MASK_I);
          m_ph = M_ARM; m_arm_done = 0;
        end
        M_ARM: begin
          m_arm_done++;
          if (m_arm_done == 16) begin
            m_ph = M_ACQ; m_acq_done = 0;
          end
        end
        M_ACQ: begin
          m_acq_done++;
          if (FLT_STABLE_I) m_ph = M_LOCK;
          else if (m_acq_done >= dwell_max || FLT_TIMEOUT_I) begin
            m_sel = pick_after(m_sel, SRC_MASK_I);
            m_ph = M_ARM; m_arm_done = 0;
          end
        end
        M_LOCK: begin
          if (!FLT_STABLE_I || FLT_TIMEOUT_I) begin
            m_lost = 1'b1;
            m_ph = M_ARM; m_arm_done = 0;
          end
        end
      endcase
    end
    m_vs = (m_ph == M_ACQ || m_ph == M_LOCK) ? vs_old : 1'b0;
  endtask

  function automatic out_t model_out();
    logic on;
    on = (m_ph == M_ACQ || m_ph == M_LOCK);
    return {on, on, m_times, m_thr, m_vs, 3'(m_sel), (m_ph == M_LOCK), m_lost, m_nosrc};
  endfunction

  // Monitor: one scoreboard comparison per cycle, away from the rising edge.
  always @(negedge CLK_I) begin
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      n_checks++;
      if (dut_o !== mon_e) begin
        n_fail++;
        $display("FAIL scoreboard cycle %0d: got %h expected %h", cyc, dut_o, mon_e);
      end
    end
  end

  task automatic chk(string name, int got, int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic tick();
    VS_I = 4'($urandom);
    FILTER_TIMES_I = 8'($urandom);
    FILTER_THRESHHOLD_CLKPRD_I = 16'($urandom);
    @(posedge CLK_I);
    cyc++;
    model_step();
    exp_q.push_back(model_out());
    #1;
  endtask

  task automatic ticks(int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_flt_en(string name);
    int b;
    b = 0;
    while (FLT_EN_O !== 1'b1 && b < 200) begin
      tick();
      b++;
    end
    if (FLT_EN_O !== 1'b1) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic go_idle();
    FLT_STABLE_I = 1'b0;
    FLT_TIMEOUT_I = 1'b0;
    EN_I = 1'b0;
    tick();
  endtask

  initial begin
    int cnt;
    int exp_sel[4];
    exp_sel = '{0, 1, 3, 0};

    // Reset with active-looking inputs.
    RST_I = 1'b1; EN_I = 1'b1; SRC_MASK_I = 4'b1111;
    ticks(3);
    chk("reset_sel", SEL_O, 0);
    chk("reset_rstn", FLT_RSTN_O, 0);
    chk("reset_times", FLT_TIMES_O, 0);
    RST_I = 1'b0;
    go_idle();

    // Single source 2: 16 ARM cycles, stable at ACQ cycle 50.
    SRC_MASK_I = 4'b0100; DWELL_CLKNUM_I = 24'd1000; EN_I = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (FLT_RSTN_O) break;
      cnt++;
    end
    chk("arm_len", cnt, 16);
    chk("arm_sel", SEL_O, 2);
    ticks(49);
    FLT_STABLE_I = 1'b1;
    tick();
    chk("lock_after_acq50", LOCK_O, 1);

    // Scan 0,1,3,0 with a 100-cycle dwell.
    go_idle();
    SRC_MASK_I = 4'b1011; DWELL_CLKNUM_I = 24'd100; EN_I = 1'b1;
    for (int a = 0; a < 4; a++) begin
      wait_flt_en("scan_wait");
      chk("scan_sel", SEL_O, exp_sel[a]);
      cnt = 1;
      for (int i = 0; i < 300; i++) begin
        tick();
        if (!FLT_EN_O) break;
        cnt++;
      end
      chk("scan_acq_len", cnt, 100);
    end

    // Lock on 1 then lose it.
    go_idle();
    SRC_MASK_I = 4'b0010; DWELL_CLKNUM_I = 24'd1000; EN_I = 1'b1;
    wait_flt_en("lost_wait");
    FLT_STABLE_I = 1'b1;
    tick();
    chk("lost_locked", LOCK_O, 1);
    ticks(3);
    FLT_STABLE_I = 1'b0;
    tick();
    chk("lost_pulse", LOCK_LOST_O, 1);
    chk("lost_sel", SEL_O, 1);
    chk("lost_rearm", FLT_RSTN_O, 0);
    tick();
    chk("lost_pulse_end", LOCK_LOST_O, 0);

    // Lock on 3, then source 3 removed from the mask.
    go_idle();
    SRC_MASK_I = 4'b1000; EN_I = 1'b1;
    wait_flt_en("mask_wait");
    FLT_STABLE_I = 1'b1;
    tick();
    chk("mask_locked_sel", SEL_O, 3);
    SRC_MASK_I = 4'b0011;
    tick();
    chk("mask_sel", SEL_O, 0);
    chk("mask_no_lost", LOCK_LOST_O, 0);
    chk("mask_rearm", FLT_RSTN_O, 0);
    RST_I = 1'b1;
    tick();
    chk("rst_in_arm_no_lost", LOCK_LOST_O, 0);
    RST_I = 1'b0;

    // Zero dwell gives one ACQ cycle; stable beats simultaneous expiry.
    go_idle();
    SRC_MASK_I = 4'b0101; DWELL_CLKNUM_I = 24'd0; EN_I = 1'b1;
    wait_flt_en("dwell0_wait");
    chk("dwell0_sel", SEL_O, 0);
    tick();
    chk("dwell0_exit", FLT_EN_O, 0);
    chk("dwell0_adv", SEL_O, 2);
    DWELL_CLKNUM_I = 24'd5;
    wait_flt_en("tie_wait");
    ticks(4);
    FLT_STABLE_I = 1'b1;
    tick();
    chk("tie_lock", LOCK_O, 1);
    chk("tie_sel", SEL_O, 2);

    // Mask emptied while locked, then scanning disabled.
    SRC_MASK_I = 4'b0000;
    tick();
    chk("nosrc_flag", NO_SRC_O, 1);
    chk("nosrc_unlock", LOCK_O, 0);
    chk("nosrc_rstn", FLT_RSTN_O, 0);
    EN_I = 1'b0;
    tick();
    chk("nosrc_clear", NO_SRC_O, 0);

    // Random phase.
    FLT_STABLE_I = 1'b0;
    SRC_MASK_I = 4'($urandom);
    DWELL_CLKNUM_I = 24'($urandom_range(0, 40));
    for (int i = 0; i < 2000; i++) begin
      RST_I = ($urandom_range(0, 199) == 0);
      EN_I = ($urandom_range(0, 49) != 0);
      if ($urandom_range(0, 63) == 0) SRC_MASK_I = 4'($urandom);
      if ($urandom_range(0, 29) == 0) FLT_STABLE_I = ~FLT_STABLE_I;
      FLT_TIMEOUT_I = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 99) == 0) DWELL_CLKNUM_I = 24'($urandom_range(0, 40));
      tick();
    end
    RST_I = 1'b0;

    @(negedge CLK_I);
    #1;
    chk("queue_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
